mem_access_unit: RTL

- Load/store sequencer between the multicycle control unit / datapath and the 64-bit synchronous data memory.
- Loads: reads the aligned doubleword, extracts the byte/half/word/double lane, and zero- or sign-extends it. This replaces the separate pre-store and post-load trimming logic.
- Stores: sub-doubleword stores use read-modify-write. Doubleword stores write directly.
- Signals completion with a one-cycle `done` pulse. The control unit stalls its state machine until `done`.

---
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer for a 64-bit synchronous data memory: lane extraction, sign/zero
// extension and read-modify-write stores. Optional macro MAU_LINE_REUSE_EN skips repeat reads.
module mem_access_unit #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic              mem_wr,
  input  logic [63:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, DONE} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  state_t            state;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [2:0]        lane_q;
  logic [63:0]       wdata_q;
  logic [63:0]       line_q;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_aligned;
  logic [63:0]       merged;
  logic              line_hit;

  function automatic logic is_illegal(input logic w, input logic [2:0] f3, input logic [2:0] a);
    logic misaligned;
    case (f3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a[1:0] != 2'b00);
      default: misaligned = (a != 3'b000);
    endcase
    return misaligned || (w && f3[2]) || (!w && f3 == 3'b111);
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] line, input logic [2:0] lane,
                                          input logic [2:0] f3);
    logic [63:0] s;
    s = line >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{56{s[7]}}, s[7:0]};
      3'b001:  return {{48{s[15]}}, s[15:0]};
      3'b010:  return {{32{s[31]}}, s[31:0]};
      3'b100:  return {56'd0, s[7:0]};
      3'b101:  return {48'd0, s[15:0]};
      3'b110:  return {32'd0, s[31:0]};
      default: return s;
    endcase
  endfunction

  // A full-width mask makes SD fall out as plain wdata, so one merge path serves all stores.
  function automatic logic [63:0] merge(input logic [63:0] line, input logic [63:0] data,
                                        input logic [2:0] lane, input logic [2:0] f3);
    logic [63:0] mask;
    case (f3[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = '1;
    endcase
    mask = mask << {lane, 3'b000};
    return (line & ~mask) | ((data << {lane, 3'b000}) & mask);
  endfunction

  assign addr_aligned = {addr[ADDR_W-1:3], 3'b000};

  always_comb begin
    merged = merge(line_q, wdata_q, lane_q, funct3_q);
  end

`ifdef MAU_LINE_REUSE_EN
  logic              line_valid;
  logic [ADDR_W-1:0] line_tag;
  assign line_hit = line_valid && (line_tag == addr_aligned);
`else
  assign line_hit = 1'b0;
`endif

  // Outputs are registered on the edge that leaves a state, so done/mem_wr appear one
  // cycle after the FSM enters DONE/WRITE; requests are refused while done is still high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
      line_q    <= '0;
      wait_cnt  <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
`ifdef MAU_LINE_REUSE_EN
      line_valid <= 1'b0;
      line_tag   <= '0;
`endif
    end else begin
      done   <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !done) begin
            we_q     <= we;
            funct3_q <= funct3;
            lane_q   <= addr[2:0];
            wdata_q  <= wdata;
            busy     <= 1'b1;
            rdata    <= '0;
            err      <= 1'b0;
            if (is_illegal(we, funct3, addr[2:0])) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              mem_addr <= addr_aligned;
              if (we && (funct3 == 3'b011 || line_hit)) begin
                state <= WRITE;
              end else if (line_hit) begin
                rdata <= extract(line_q, addr[2:0], funct3);
                state <= DONE;
              end else begin
                wait_cnt <= LAT_INIT;
                state    <= RD_WAIT;
              end
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (wait_cnt == '0) begin
            line_q <= mem_rdata;
`ifdef MAU_LINE_REUSE_EN
            line_valid <= 1'b1;
            line_tag   <= mem_addr;
`endif
            if (we_q) begin
              state <= WRITE;
            end else begin
              rdata <= extract(mem_rdata, lane_q, funct3_q);
              state <= DONE;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        WRITE: begin
          mem_wr    <= 1'b1;
          mem_wdata <= merged;
`ifdef MAU_LINE_REUSE_EN
          line_q     <= merged;
          line_valid <= 1'b1;
          line_tag   <= mem_addr;
`endif
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
